// File: rtl/trk_pkg.sv
// trk_pkg: shared definitions for the two-track note recorder sequencer.
//   - TRK_ADDR_W / TRK_DATA_W : default SRAM address and note byte widths
//   - TRK_DEPTH               : default track depth (2**TRK_ADDR_W)
//   - trk_state_t             : sequencer state (IDLE / REC / PLAY)
package trk_pkg;

  localparam int unsigned TRK_ADDR_W = 8;
  localparam int unsigned TRK_DATA_W = 8;
  localparam int unsigned TRK_DEPTH  = 2 ** TRK_ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } trk_state_t;

endpackage

// File: rtl/trk_addr_cnt.sv
// trk_addr_cnt: shared SRAM address counter used by record and playback passes.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear to 0 (wins over inc)
//   inc      : increment enable
//   addr     : current address (registered)
//   tc       : terminal count, addr == all ones
module trk_addr_cnt #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      addr <= '0;
    end else if (inc) begin
      addr <= addr + ONE;
    end
  end

  assign tc = &addr;

endmodule

// File: rtl/track_seq_ctrl.sv
// track_seq_ctrl: record/playback sequencer for two 8-bit note SRAMs.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   rec_btn, play_btn, stop_btn : one-cycle button pulses
//   trk_sel[1:0]                : bit0 track one, bit1 track two
//   tick                        : note-rate strobe
//   key_in                      : live key byte recorded on tick
//   sram_en[1:0], sram_rw       : per-track enable, 1 = write
//   sram_addr, sram_din         : shared address, write data
//   busy, done                  : pass active, natural end-of-pass pulse
//   len0, len1                  : recorded length per track (0..DEPTH)
// Build option: define TRK_LOOP_EN to make playback wrap and continue
// until stop_btn (done pulses once per wrap).
module track_seq_ctrl
  import trk_pkg::*;
#(
  parameter int unsigned ADDR_W = TRK_ADDR_W,
  parameter int unsigned DATA_W = TRK_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_btn,
  input  logic              play_btn,
  input  logic              stop_btn,
  input  logic [1:0]        trk_sel,
  input  logic              tick,
  input  logic [DATA_W-1:0] key_in,
  output logic [1:0]        sram_en,
  output logic              sram_rw,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   len0,
  output logic [ADDR_W:0]   len1
);

  typedef logic [ADDR_W:0] len_t;

  trk_state_t        state, state_nx;
  logic              tgt, tgt_nx;          // record target: 0 track one, 1 track two
  logic [1:0]        sel_q, sel_nx;        // playback selection latched at entry
  len_t              play_len, play_len_nx;
  logic              pend, pend_nx;        // write strobe is on the bus this cycle
  logic [1:0]        en_nx;
  logic              rw_nx, done_nx;
  logic [DATA_W-1:0] din_nx;
  len_t              len0_nx, len1_nx;
  logic              cnt_clr, cnt_inc, cnt_tc;
  logic [ADDR_W-1:0] cnt_addr;
  len_t              addr_ext, addr_p1, addr_nx_ext;

  function automatic len_t max_len(input logic [1:0] sel, input len_t a, input len_t b);
    len_t la, lb;
    la = sel[0] ? a : '0;
    lb = sel[1] ? b : '0;
    return (la > lb) ? la : lb;
  endfunction

  trk_addr_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .addr (cnt_addr),
    .tc   (cnt_tc)
  );

  assign sram_addr = cnt_addr;
  assign addr_ext  = {1'b0, cnt_addr};
  assign addr_p1   = addr_ext + len_t'(1);

  always_comb begin
    state_nx    = state;
    tgt_nx      = tgt;
    sel_nx      = sel_q;
    play_len_nx = play_len;
    pend_nx     = 1'b0;
    en_nx       = '0;
    rw_nx       = 1'b0;
    din_nx      = sram_din;
    done_nx     = 1'b0;
    len0_nx     = len0;
    len1_nx     = len1;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    addr_nx_ext = addr_ext;
    case (state)
      IDLE: begin
        if (rec_btn && (trk_sel != 2'b00)) begin
          state_nx = REC;
          tgt_nx   = ~trk_sel[0];
          cnt_clr  = 1'b1;
          if (trk_sel[0]) len0_nx = '0;
          else            len1_nx = '0;
        end else if (play_btn && ((trk_sel[0] && (len0 != '0)) ||
                                  (trk_sel[1] && (len1 != '0)))) begin
          state_nx    = PLAY;
          sel_nx      = trk_sel;
          play_len_nx = max_len(trk_sel, len0, len1);
          cnt_clr     = 1'b1;
          en_nx       = {trk_sel[1] && (len1 != '0), trk_sel[0] && (len0 != '0)};
        end
      end
      REC: begin
        if (pend) begin
          // The strobe already reached the SRAM, so the write counts even if
          // stop arrives in this cycle.
          if (tgt) len1_nx = addr_p1;
          else     len0_nx = addr_p1;
          if (stop_btn || cnt_tc) begin
            state_nx = IDLE;
            cnt_clr  = 1'b1;
            done_nx  = ~stop_btn;
          end else begin
            cnt_inc = 1'b1;
          end
        end else if (stop_btn) begin
          state_nx = IDLE;
          cnt_clr  = 1'b1;
        end else if (tick) begin
          pend_nx = 1'b1;
          rw_nx   = 1'b1;
          din_nx  = key_in;
          en_nx   = tgt ? 2'b10 : 2'b01;
        end
      end
      PLAY: begin
        if (stop_btn) begin
          state_nx = IDLE;
          cnt_clr  = 1'b1;
        end else begin
          if (tick) begin
            if (addr_p1 == play_len) begin
              done_nx     = 1'b1;
              cnt_clr     = 1'b1;
              addr_nx_ext = '0;
`ifdef TRK_LOOP_EN
              state_nx = PLAY;
`else
              state_nx = IDLE;
`endif
            end else begin
              cnt_inc     = 1'b1;
              addr_nx_ext = addr_p1;
            end
          end
          // Enables are registered, so they are computed for the next address.
          if (state_nx == PLAY) begin
            en_nx = {sel_q[1] && (addr_nx_ext < len1), sel_q[0] && (addr_nx_ext < len0)};
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_clr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tgt      <= 1'b0;
      sel_q    <= '0;
      play_len <= '0;
      pend     <= 1'b0;
      sram_en  <= '0;
      sram_rw  <= 1'b0;
      sram_din <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      len0     <= '0;
      len1     <= '0;
    end else begin
      state    <= state_nx;
      tgt      <= tgt_nx;
      sel_q    <= sel_nx;
      play_len <= play_len_nx;
      pend     <= pend_nx;
      sram_en  <= en_nx;
      sram_rw  <= rw_nx;
      sram_din <= din_nx;
      busy     <= (state_nx != IDLE);
      done     <= done_nx;
      len0     <= len0_nx;
      len1     <= len1_nx;
    end
  end

endmodule

// File: tb/tb_track_seq_ctrl.sv
// tb_track_seq_ctrl: self-checking bench for track_seq_ctrl.
// A behavioural model of the recorder (integer lengths, address, pending
// write) is stepped on every rising edge; its view of the outputs is compared
// with the DUT on every falling edge. Directed scenarios add literal checks.
module tb_track_seq_ctrl;
  import trk_pkg::*;

  localparam int AW    = TRK_ADDR_W;
  localparam int DW    = TRK_DATA_W;
  localparam int DEPTH = TRK_DEPTH;

  logic          clk = 1'b0;
  logic          rst, rec_btn, play_btn, stop_btn, tick;
  logic [1:0]    trk_sel;
  logic [DW-1:0] key_in;
  logic [1:0]    sram_en;
  logic          sram_rw, busy, done;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [AW:0]   len0, len1;

  always #5 clk = ~clk;

  track_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .rec_btn(rec_btn), .play_btn(play_btn), .stop_btn(stop_btn),
    .trk_sel(trk_sel), .tick(tick), .key_in(key_in), .sram_en(sram_en), .sram_rw(sram_rw),
    .sram_addr(sram_addr), .sram_din(sram_din), .busy(busy), .done(done),
    .len0(len0), .len1(len1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic cmp(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_mode;   // 0 idle, 1 recording, 2 playing
  int       m_addr;
  int       m_len[2];
  int       m_tgt;
  logic [1:0] m_sel;
  int       m_plen;
  bit       m_pend;
  int       m_data;
  bit       m_done;
  bit       m_valid = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_addr = 0; m_len[0] = 0; m_len[1] = 0; m_tgt = 0;
      m_sel = 0; m_plen = 0; m_pend = 0; m_data = 0; m_done = 0; m_valid = 1;
    end else if (m_valid) begin
      m_done = 0;
      case (m_mode)
        0: begin
          if (rec_btn && trk_sel != 0) begin
            m_mode = 1; m_tgt = trk_sel[0] ? 0 : 1; m_len[m_tgt] = 0; m_addr = 0;
          end else if (play_btn && ((trk_sel[0] && m_len[0] > 0) || (trk_sel[1] && m_len[1] > 0))) begin
            int a, b;
            a = trk_sel[0] ? m_len[0] : 0;
            b = trk_sel[1] ? m_len[1] : 0;
            m_mode = 2; m_sel = trk_sel; m_plen = (a > b) ? a : b; m_addr = 0;
          end
        end
        1: begin
          if (m_pend) begin
            m_pend = 0;
            m_len[m_tgt] = m_addr + 1;
            if (stop_btn) begin m_mode = 0; m_addr = 0; end
            else if (m_addr == DEPTH - 1) begin m_done = 1; m_mode = 0; m_addr = 0; end
            else m_addr++;
          end else if (stop_btn) begin
            m_mode = 0; m_addr = 0;
          end else if (tick) begin
            m_pend = 1; m_data = int'(key_in);
          end
        end
        default: begin
          if (stop_btn) begin
            m_mode = 0; m_addr = 0;
          end else if (tick) begin
            if (m_addr + 1 == m_plen) begin
              m_done = 1; m_addr = 0;
`ifndef TRK_LOOP_EN
              m_mode = 0;
`endif
            end else m_addr++;
          end
        end
      endcase
    end
  end

  function automatic int model_en();
    int e = 0;
    if (m_mode == 1 && m_pend) e = 1 << m_tgt;
    if (m_mode == 2) begin
      if (m_sel[0] && m_addr < m_len[0]) e |= 1;
      if (m_sel[1] && m_addr < m_len[1]) e |= 2;
    end
    return e;
  endfunction

  // ---------------- compare process + write log ----------------
  int w_addr[$];
  int w_data[$];
  int w_en[$];
  int done_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      cmp("busy",  busy,      (m_mode != 0) ? 1 : 0);
      cmp("done",  done,      m_done ? 1 : 0);
      cmp("rw",    sram_rw,   m_pend ? 1 : 0);
      cmp("en",    sram_en,   model_en());
      cmp("addr",  sram_addr, m_addr);
      cmp("len0",  len0,      m_len[0]);
      cmp("len1",  len1,      m_len[1]);
      if (m_pend) cmp("din", sram_din, m_data);
      if (sram_rw === 1'b1) begin
        w_addr.push_back(int'(sram_addr));
        w_data.push_back(int'(sram_din));
        w_en.push_back(int'(sram_en));
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic r, input logic p, input logic s, input logic t,
                      input logic [1:0] sel, input logic [DW-1:0] k);
    @(negedge clk);
    rec_btn = r; play_btn = p; stop_btn = s; tick = t; trk_sel = sel; key_in = k;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, trk_sel, key_in);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rec_btn = 0; play_btn = 0; stop_btn = 0; tick = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : main
    logic [DW-1:0] keys [3];
    int dc;
    keys[0] = 8'h11; keys[1] = 8'h22; keys[2] = 8'h33;
    rst = 1'b1; rec_btn = 0; play_btn = 0; stop_btn = 0; tick = 0; trk_sel = 0; key_in = 0;
    repeat (3) @(negedge clk);
    cmp("rst_busy", busy, 0);
    cmp("rst_en",   sram_en, 0);
    cmp("rst_len0", len0, 0);
    cmp("rst_addr", sram_addr, 0);
    rst = 1'b0;

    // Record 3 notes into track one, then stop.
    w_addr.delete(); w_data.delete(); w_en.delete();
    dc = done_cnt;
    step(1, 0, 0, 0, 2'b01, 0);
    idle(1);
    cmp("rec_entry_busy", busy, 1);
    cmp("rec_entry_addr", sram_addr, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 2'b01, keys[i]);
      idle(2);
    end
    step(0, 0, 1, 0, 2'b01, 0);
    idle(2);
    cmp("rec3_len0", len0, 3);
    cmp("rec3_busy", busy, 0);
    cmp("rec3_nodone", done_cnt, dc);
    cmp("rec3_nwrites", w_addr.size(), 3);
    for (int i = 0; i < 3 && i < w_addr.size(); i++) begin
      cmp("rec3_waddr", w_addr[i], i);
      cmp("rec3_wdata", w_data[i], int'(keys[i]));
      cmp("rec3_wen",   w_en[i], 1);
    end

    // Record 5 notes into track two.
    step(1, 0, 0, 0, 2'b10, 0);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 2'b10, 8'(8'h40 + i));
      idle(2);
    end
    step(0, 0, 1, 0, 2'b10, 0);
    idle(2);
    cmp("rec5_len1", len1, 5);
    cmp("rec5_len0_kept", len0, 3);

    // Play both tracks.
    step(0, 1, 0, 0, 2'b11, 0);
    idle(1);
    cmp("play_en0", sram_en, 3);
    cmp("play_addr0", sram_addr, 0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 1, 2'b11, 0);
      idle(1);
      cmp("play_addr", sram_addr, i);
      cmp("play_en", sram_en, (i < 3) ? 3 : 2);
    end
    step(0, 0, 0, 1, 2'b11, 0);
    idle(1);
    cmp("play_done", done, 1);
    cmp("play_end_busy", busy, 0);

    // Ignored starts.
    step(1, 0, 0, 0, 2'b00, 0);
    idle(1);
    cmp("rec_sel0_busy", busy, 0);
    do_reset();
    cmp("reset_len0", len0, 0);
    cmp("reset_len1", len1, 0);
    step(0, 1, 0, 0, 2'b11, 0);
    idle(1);
    cmp("play_empty_busy", busy, 0);

    // Full-depth recording into track two.
    w_addr.delete(); w_data.delete(); w_en.delete();
    step(1, 0, 0, 0, 2'b10, 0);
    idle(1);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 1, 2'b10, 8'(i) ^ 8'hA5);
      idle(1);
    end
    idle(1);
    cmp("full_done", done, 1);
    cmp("full_busy", busy, 0);
    cmp("full_len1", len1, DEPTH);
    cmp("full_nwrites", w_addr.size(), DEPTH);
    if (w_addr.size() == DEPTH) begin
      cmp("full_last_addr", w_addr[DEPTH-1], DEPTH - 1);
      cmp("full_last_en", w_en[DEPTH-1], 2);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 2'b10, 8'h99);
      idle(2);
    end
    cmp("full_after_nwrites", w_addr.size(), DEPTH);

    // Stop coincident with tick after 2 writes.
    w_addr.delete(); w_data.delete(); w_en.delete();
    step(1, 0, 0, 0, 2'b01, 0);
    idle(1);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 1, 2'b01, 8'(8'h60 + i));
      idle(2);
    end
    step(0, 0, 1, 1, 2'b01, 8'h77);
    idle(2);
    cmp("stoptick_len0", len0, 2);
    cmp("stoptick_nwrites", w_addr.size(), 2);
    cmp("stoptick_busy", busy, 0);

    // Reset in the middle of playback.
    step(0, 1, 0, 0, 2'b01, 0);
    idle(1);
    step(0, 0, 0, 1, 2'b01, 0);
    idle(1);
    cmp("midplay_busy", busy, 1);
    cmp("midplay_addr", sram_addr, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp("rstplay_busy", busy, 0);
    cmp("rstplay_en", sram_en, 0);
    cmp("rstplay_addr", sram_addr, 0);
    cmp("rstplay_len0", len0, 0);
    rst = 1'b0;

`ifdef TRK_LOOP_EN
    // Looping playback of a 2-note track.
    step(1, 0, 0, 0, 2'b01, 0);
    idle(1);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 1, 2'b01, 8'(i));
      idle(2);
    end
    step(0, 0, 1, 0, 2'b01, 0);
    idle(2);
    step(0, 1, 0, 0, 2'b01, 0);
    idle(1);
    cmp("loop_addr0", sram_addr, 0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 1, 2'b01, 0);
      idle(1);
      cmp("loop_addr", sram_addr, i % 2);
      cmp("loop_done", done, (i % 2 == 0) ? 1 : 0);
      cmp("loop_busy", busy, 1);
    end
    step(0, 0, 1, 0, 2'b01, 0);
    idle(1);
    cmp("loop_stop_busy", busy, 0);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 599) == 0);
      rec_btn  = ($urandom_range(0, 39) == 0);
      play_btn = ($urandom_range(0, 29) == 0);
      stop_btn = ($urandom_range(0, 79) == 0);
      tick     = !tick && ($urandom_range(0, 2) == 0);
      trk_sel  = 2'($urandom);
      key_in   = DW'($urandom);
    end
    @(negedge clk);
    rst = 0; rec_btn = 0; play_btn = 0; stop_btn = 0; tick = 0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
